// File: rtl/ppu_pkg.sv
// ppu_pkg: shared capture FSM states and LCD geometry
package ppu_pkg;
  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, ACTIVE} cap_state_t;
  localparam int LCD_W_DEF = 160;
  localparam int LCD_H_DEF = 144;
  localparam int BYTES_PER_LINE = LCD_W_DEF / 4;
  localparam int OFF_W = 13;
  function automatic int bytes_per_line(input int w);
    return w / 4;
  endfunction
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: shifts 2-bit shades MSB-first into a byte, flags the 4th pixel
module pixel_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift,
  input  logic [1:0] color,
  output logic [7:0] pk_byte,
  output logic       ready
);
  logic [5:0] sr;
  logic [1:0] cnt;
  assign pk_byte = {sr, color};
  assign ready = shift & (cnt == 2'd3);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[3:0], color};
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/lcd_capture.sv
// lcd_capture: captures a 2-bit LCD pixel stream into a double-buffered framebuffer
module lcd_capture
  import ppu_pkg::*;
#(
  parameter int LCD_W = LCD_W_DEF,
  parameter int LCD_H = LCD_H_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_d_wr,
  output logic        fb_write,
  output logic        disp_bank,
  output logic        frame_done,
  output logic        err,
  input  logic        err_clr
);
  localparam int XW = $clog2(LCD_W + 1);
  localparam int YW = $clog2(LCD_H + 1);
  localparam logic [XW-1:0] X_MAX = XW'(LCD_W);
  localparam logic [YW-1:0] Y_MAX = YW'(LCD_H);
  localparam logic [OFF_W-1:0] BPL = OFF_W'(bytes_per_line(LCD_W));

  cap_state_t state, state_n;
  logic hs_d, vs_d;
  logic [XW-1:0] x, x_acc;
  logic [YW-1:0] y;
  logic hs_rise, vs_rise, vs_fall;
  logic in_line, start, pix, acc, line_end, frame_end, frame_ok, err_ev, wr;
  logic [7:0] pk_byte;
  logic [OFF_W-1:0] off;

  assign hs_rise = lcd_hsync & ~hs_d;
  assign vs_rise = lcd_vsync & ~vs_d;
  assign vs_fall = ~lcd_vsync & vs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_FRAME;
    else state <= state_n;
  end

  always_comb begin
    state_n = (state == WAIT_FRAME) ? (vs_fall ? WAIT_LINE : WAIT_FRAME) :
              frame_end ? WAIT_FRAME :
              line_end ? WAIT_LINE :
              (state == WAIT_LINE && pix) ? ACTIVE : state;
  end

  // a pixel arriving with the hsync edge is accepted before the line closes
  always_comb begin
    in_line   = state != WAIT_FRAME;
    start     = (state == WAIT_FRAME) & vs_fall;
    pix       = in_line & lcd_pixel;
    acc       = pix & (x < X_MAX) & (y < Y_MAX);
    x_acc     = x + XW'(acc);
    line_end  = (state == ACTIVE) & hs_rise;
    frame_end = in_line & vs_rise;
    frame_ok  = frame_end & (y == Y_MAX);
    err_ev    = (pix & ~acc) | (line_end & (x_acc != X_MAX)) | (frame_end & ~frame_ok);
    off       = OFF_W'(y) * BPL + OFF_W'(x >> 2);
  end

  pixel_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start | line_end),
    .shift   (acc),
    .color   (lcd_color),
    .pk_byte (pk_byte),
    .ready   (wr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      x          <= '0;
      y          <= '0;
      fb_write   <= 1'b0;
      fb_addr    <= '0;
      fb_d_wr    <= '0;
      frame_done <= 1'b0;
      disp_bank  <= 1'b0;
      err        <= 1'b0;
    end else begin
      hs_d       <= lcd_hsync;
      vs_d       <= lcd_vsync;
      x          <= (start | line_end) ? '0 : x_acc;
      y          <= start ? '0 : (line_end && y < Y_MAX) ? y + YW'(1) : y;
      fb_write   <= wr;
      fb_addr    <= wr ? {~disp_bank, off} : fb_addr;
      fb_d_wr    <= wr ? pk_byte : fb_d_wr;
      frame_done <= frame_ok;
      disp_bank  <= disp_bank ^ frame_ok;
      err        <= err_ev | (err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed frames with a write scoreboard for lcd_capture
module tb_lcd_capture;
  logic clk = 1'b0;
  logic rst_n, lcd_hsync, lcd_vsync, lcd_pixel, err_clr;
  logic [1:0] lcd_color;
  logic [13:0] fb_addr;
  logic [7:0] fb_d_wr;
  logic fb_write, disp_bank, frame_done, err;
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic wbank;
  logic [7:0] b;
  logic [21:0] q[$];

  always #5 clk = ~clk;

  lcd_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .lcd_pixel  (lcd_pixel),
    .lcd_color  (lcd_color),
    .fb_addr    (fb_addr),
    .fb_d_wr    (fb_d_wr),
    .fb_write   (fb_write),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .err        (err),
    .err_clr    (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // every cycle: observe 1 time unit after the edge and pop the scoreboard on writes
  task automatic cyc();
    logic [21:0] e;
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (fb_write) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '1;
      chk("write", 32'({fb_addr, fb_d_wr}), 32'(e));
    end
  endtask

  task automatic send_line(input int n, input int ly, input bit rnd, input bit push,
                           input int rel, input bit tail);
    lcd_hsync = 1'b0;
    lcd_pixel = 1'b0;
    cyc();
    for (int i = 0; i < n; i++) begin
      logic [1:0] c;
      c = rnd ? 2'($urandom_range(3)) : 2'(i % 4);
      if (i == rel) rst_n = 1'b1;
      lcd_pixel = 1'b1;
      lcd_color = c;
      b = {b[5:0], c};
      if (push && i < 160 && ly < 144 && i % 4 == 3)
        q.push_back({wbank, 13'(ly * 40 + i / 4), b});
      cyc();
    end
    if (tail) begin
      lcd_pixel = 1'b0;
      lcd_hsync = 1'b1;
      repeat (3) cyc();
    end
  endtask

  task automatic frame_start();
    lcd_vsync = 1'b1;
    lcd_hsync = 1'b1;
    lcd_pixel = 1'b0;
    repeat (4) cyc();
    lcd_vsync = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic frame_end();
    lcd_vsync = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    lcd_hsync = 1'b1;
    lcd_vsync = 1'b1;
    lcd_pixel = 1'b0;
    lcd_color = 2'd0;
    err_clr = 1'b0;
    b = 8'h00;
    repeat (2) cyc();
    chk("rst_write", 32'(fb_write), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_d_wr), 0);
    chk("rst_bank", 32'(disp_bank), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    // full frame with the x%4 shade pattern
    wbank = 1'b1;
    frame_start();
    for (int ly = 0; ly < 144; ly++) send_line(160, ly, 1'b0, 1'b1, -1, 1'b1);
    frame_end();
    chk("full_pending", 32'(q.size()), 0);
    chk("full_last_addr", 32'(fb_addr), 32'({1'b1, 13'd5759}));
    chk("full_last_byte", 32'(fb_d_wr), 32'h1B);
    chk("full_done", 32'(fd_cnt), 1);
    chk("full_bank", 32'(disp_bank), 1);
    chk("full_err", 32'(err), 0);

    // long line, short line, then a short frame
    wbank = 1'b0;
    frame_start();
    send_line(162, 0, 1'b1, 1'b1, -1, 1'b1);
    chk("long_err", 32'(err), 1);
    chk("long_pending", 32'(q.size()), 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("long_clr", 32'(err), 0);
    for (int ly = 1; ly < 5; ly++) send_line(160, ly, 1'b1, 1'b1, -1, 1'b1);
    chk("good_lines_err", 32'(err), 0);
    send_line(158, 5, 1'b1, 1'b1, -1, 1'b1);
    chk("short_err", 32'(err), 1);
    send_line(160, 6, 1'b1, 1'b1, -1, 1'b1);
    chk("short_pending", 32'(q.size()), 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("short_clr", 32'(err), 0);
    lcd_vsync = 1'b1;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("sf_err_beats_clr", 32'(err), 1);
    repeat (2) cyc();
    chk("sf_done", 32'(fd_cnt), 1);
    chk("sf_bank", 32'(disp_bank), 1);
    chk("sf_err", 32'(err), 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("sf_clr", 32'(err), 0);

    // reset at x=80 of line 10, released during line 70
    wbank = 1'b0;
    frame_start();
    for (int ly = 0; ly < 10; ly++) send_line(160, ly, 1'b1, 1'b1, -1, 1'b1);
    send_line(80, 10, 1'b1, 1'b1, -1, 1'b0);
    rst_n = 1'b0;
    lcd_color = 2'd2;
    cyc();
    chk("mid_rst_write", 32'(fb_write), 0);
    chk("mid_rst_addr", 32'(fb_addr), 0);
    chk("mid_rst_data", 32'(fb_d_wr), 0);
    chk("mid_rst_bank", 32'(disp_bank), 0);
    chk("mid_rst_done", 32'(frame_done), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_pending", 32'(q.size()), 0);
    lcd_pixel = 1'b0;
    lcd_hsync = 1'b1;
    repeat (3) cyc();
    for (int ly = 11; ly < 73; ly++) send_line(160, ly, 1'b1, 1'b0, ly == 70 ? 20 : -1, 1'b1);
    chk("restart_bank", 32'(disp_bank), 0);
    chk("restart_err", 32'(err), 0);
    chk("restart_done", 32'(fd_cnt), 1);
    frame_end();

    // clean frame after restart plus one surplus line past LCD_H
    wbank = 1'b1;
    frame_start();
    for (int ly = 0; ly < 145; ly++) send_line(160, ly, ly % 3 == 0, 1'b1, -1, 1'b1);
    frame_end();
    chk("final_pending", 32'(q.size()), 0);
    chk("final_done", 32'(fd_cnt), 2);
    chk("final_bank", 32'(disp_bank), 1);
    chk("final_err", 32'(err), 1);
    chk("final_addr", 32'(fb_addr), 32'({1'b1, 13'd5759}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_capture.md
LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 SHALL have parameter LCD_W, default 160, meaning active pixels per line.
REQ-002 SHALL have parameter LCD_H, default 144, meaning active lines per frame.
REQ-003 SHALL have port clk  input  1  system clock, the same clock as the display stream source.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have ports lcd_hsync, lcd_vsync, lcd_pixel  input  1 each  display stream: hblank level, vblank level, pixel-valid strobe.
REQ-006 SHALL have port lcd_color  input  2  shade of the current pixel, valid when lcd_pixel=1.
REQ-007 SHALL have port fb_addr  output  14  framebuffer byte address {bank, offset[12:0]}.
REQ-008 SHALL have port fb_d_wr  output  8  packed byte of 4 pixels.
REQ-009 SHALL have port fb_write  output  1  single-cycle write strobe.
REQ-010 SHALL have port disp_bank  output  1  bank that holds the last complete frame; writes target ~disp_bank.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each completed frame.
REQ-012 SHALL have port err  output  1  sticky stream-error flag.
REQ-013 SHALL have port err_clr  input  1  clears err.

Function
REQ-014 SHALL sample all lcd_* inputs every clk and keep a one-cycle-delayed copy of hsync and vsync for edge detection.
REQ-015 SHALL use FSM states WAIT_FRAME, WAIT_LINE, ACTIVE.
REQ-016 WAIT_FRAME SHALL ignore pixels and SHALL go to WAIT_LINE on a vsync falling edge, clearing x and y.
REQ-017 WAIT_LINE SHALL go to ACTIVE on the first lcd_pixel=1 sample, accepting that pixel.
REQ-018 ACTIVE SHALL accept each lcd_pixel=1 sample while x<LCD_W and increment x; an accepted pixel is a sample taken while x<LCD_W.
REQ-019 SHALL pack accepted pixels MSB-first: pixel x%4=0 goes in bits [7:6], and so on through x%4=3 in bits [1:0].
REQ-020 On the 4th pixel of a group, SHALL assert fb_write for exactly one cycle on the next clk.
REQ-021 That write SHALL carry fb_addr={~disp_bank, y*(LCD_W/4)+x/4} and the packed byte, so write latency is 1 cycle.
REQ-022 A pixel sample taken while x=LCD_W SHALL be dropped and SHALL set err.
REQ-023 An hsync rising edge in ACTIVE SHALL end the line: reset x, increment y, go to WAIT_LINE.
REQ-024 If a line ends with x!=LCD_W, SHALL set err and discard the partial byte.
REQ-025 If a pixel and an hsync rising edge occur in the same cycle, SHALL accept the pixel first, then end the line.
REQ-026 A vsync rising edge with y=LCD_H SHALL pulse frame_done the next cycle and toggle disp_bank in that same cycle, then go to WAIT_FRAME.
REQ-027 A vsync rising edge with y!=LCD_H SHALL set err, leave disp_bank unchanged, not pulse frame_done, and go to WAIT_FRAME.
REQ-028 y SHALL saturate at LCD_H; lines beyond it SHALL write nothing and SHALL set err.
REQ-029 If err_clr and an error event occur in the same cycle, the error event SHALL win.
REQ-030 Offset arithmetic SHALL use 13 bits; the maximum offset SHALL be 5759 for the default parameters.

Reset
REQ-031 When rst_n=0 at a clk edge, SHALL force state to WAIT_FRAME and clear x, y, and the packed byte.
REQ-032 On the same reset, SHALL clear the edge registers, fb_write, frame_done, disp_bank and err to 0, and set fb_addr=0 and fb_d_wr=0.
REQ-033 A reset asserted mid-frame SHALL abort that frame with no further writes.
REQ-034 After reset, capture SHALL restart only at the next vsync falling edge.

Structure
REQ-035 SHALL place the FSM state enum, LCD_W/LCD_H defaults and the bytes-per-line constant in shared package ppu_pkg.
REQ-036 SHALL implement pixel packing (2-bit shift into byte, group-count, byte-ready) as sub-module pixel_packer.

Verification
REQ-037 Full frame: vblank, then 144 lines of 160 pixels each with color=x%4 -> 5760 writes, each byte 0x1B, final fb_addr={1,5759}, frame_done pulses once, disp_bank becomes 1.
REQ-038 Long line: line 0 has 162 pixels -> 40 writes for that line, err=1, line 1 starts at offset 40.
REQ-039 Short line: line 5 has 158 pixels -> 39 writes for that line, err=1, line 6 starts at offset 240.
REQ-040 Start mid-frame: release reset during line 70 -> no writes until after the next vsync fall; the following full frame completes normally.
REQ-041 Short frame: vsync rises after 100 lines -> no frame_done pulse, disp_bank unchanged, err=1; assert err_clr -> err=0 next cycle.
REQ-042 Reset mid-line: assert rst_n=0 at x=80 of line 10 -> next cycle fb_write=0 and all outputs at reset values.
